// File: rtl/fetch_unit.sv
// Purpose : instruction-fetch front end; owns the PC, fetches one word per cycle
//           from a combinational ROM and buffers {pc, instr} in a DEPTH-entry FIFO.
// Latency : a word fetched at edge N is presented with out_valid = 1 after edge N;
//           redirect penalty is two cycles.
// Backpressure: out_valid/out_ready handshake; when the FIFO is full and not
//           popping, fetch stalls and the PC holds.
// Ports   : clk, rst (async, active-high); imem_addr/imem_data (ROM side);
//           halt, redirect_valid, redirect_pc (control);
//           out_valid, out_ready, out_instr, out_pc, out_pc_plus4 (decode side).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  // Only DEPTH 2 or 4 is legal, so pointers wrap naturally at their width.
  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             fetch;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign fetch     = ~halt & ~redirect_valid & ((count < FULL_CNT) | pop);

  assign head         = mem[rd_ptr];
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Any same-cycle pop is complete; everything else in the FIFO is dropped.
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (fetch && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !fetch) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid = 1.
  always_ff @(posedge clk) begin
    if (fetch) begin
      mem[wr_ptr] <= {pc, imem_data};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign imem_data = rom(imem_addr);

  // Reference model: queue of buffered fetches plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mpc;

  typedef struct {
    logic        h;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("m_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("m_addr", imem_addr, mpc);
    if (q.size() != 0) begin
      chk("m_pc", out_pc, q[0].pc);
      chk("m_instr", out_instr, q[0].instr);
      chk("m_plus4", out_pc_plus4, q[0].pc + 32'd4);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic cycle(input logic h, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit pop;
    bit fetch_ok;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    pop = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      mpc = rpc & ~32'h3;
    end else begin
      fetch_ok = !h && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (fetch_ok) begin
        q.push_back('{mpc, rom(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    mpc = RESET_PC;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #2;

    // Directed table: {halt, redirect, target, ready, exp_valid, exp_pc, exp_addr}
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0008};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_000C};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_000C};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_000C};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 32'h0000_0010};
    tbl[6]  = '{1'b0, 1'b1, 32'h103,       1'b1, 1'b0, 32'h0000_0000, 32'h0000_0100};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 32'h0000_0104};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 32'h0000_0104};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0104};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0104, 32'h0000_0108};
    tbl[11] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFF8};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004};

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].h, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), out_instr, 32'hA000_0000 + (tbl[i].epc >> 2));
        chk($sformatf("tbl%0d_plus4", i), out_pc_plus4, tbl[i].epc + 32'd4);
      end
    end

    // Back-pressure from reset: FIFO saturates, PC holds at 8, order kept.
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head0", out_pc, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_head4", out_pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_head8", out_pc, 32'h8);

    // Redirect while popping head 0x10 of a full FIFO; 0x14 is dropped.
    cycle(1'b0, 1'b1, 32'h10, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rd_full_head", out_pc, 32'h10);
    cycle(1'b0, 1'b1, 32'h103, 1'b1);
    chk("rd_valid0", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_valid1", {31'd0, out_valid}, 32'd1);
    chk("rd_pc", out_pc, 32'h100);

    // Halt drains two buffered entries, then holds the fetch address.
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_empty", {31'd0, out_valid}, 32'd0);
    chk("halt_addr", imem_addr, 32'h108);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_hold", imem_addr, 32'h108);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_resume", out_pc, 32'h108);

    // Async reset between edges with a full FIFO.
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    q.delete();
    mpc = RESET_PC;
    #2;
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("arst_restart_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_restart_pc", out_pc, RESET_PC);

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      logic        h, rv, rdy;
      logic [31:0] tgt;
      h   = ($urandom_range(0, 9) < 2);
      rv  = ($urandom_range(0, 9) < 1);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(h, rv, tgt, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the single-cycle core; sits directly upstream of the instruction ROM and drives its byte address. Owns the program counter, issues one word-aligned fetch per cycle into the combinational ROM, and captures each returned instruction with its PC in a 2-entry FIFO. It presents them to decode over a valid/ready handshake and supports redirects (branch/jump) that flush buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, FIFO entries; legal values 2 or 4
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  byte address to ROM; equals current PC
- imem_data  in  32  instruction word from ROM, valid in the same cycle as imem_addr
- halt  in  1  when 1, no new fetches are issued; buffered entries still drain
- redirect_valid  in  1  redirect request for this cycle
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 on load
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  PC of out_instr
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32

## Operation
- State: pc register (32b), FIFO of DEPTH entries {pc, instr}, read pointer, write pointer, count (0..DEPTH).
- imem_addr = pc combinationally.
- pop = out_valid & out_ready.
- fetch = !halt & !redirect_valid & (count < DEPTH | pop).
- On fetch: push {pc, imem_data} at write pointer; pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- On pop: advance read pointer.
- count update: +1 on fetch only, -1 on pop only, unchanged on both or neither.
- Redirect (highest priority): pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed (count <= 0, pointers reset). A pop in the same cycle counts as completed: the consumer has taken that head; all other entries are discarded. No push in a redirect cycle.
- halt has no effect on redirect or pops; halt with redirect still loads the new pc.
- Pointers wrap modulo DEPTH.
- Full: count == DEPTH with no pop -> no fetch, pc holds. Empty: out_valid = 0. out_instr/out_pc then show the stale head; the consumer must not use them.

## Timing
- Reset (async assert, any time including mid-stream): pc = RESET_PC, count = 0, out_valid = 0, imem_addr = RESET_PC immediately. out_instr/out_pc/out_pc_plus4 are don't-care while out_valid = 0.
- Fetch-to-output latency: a word fetched at edge N is visible with out_valid = 1 after edge N. It can be popped in cycle N+1.
- Steady state with out_ready = 1, no halt/redirect: one instruction per cycle, PCs consecutive, no bubbles after the first cycle.
- Redirect asserted in cycle N: after edge N, out_valid = 0 and imem_addr = target. The first target instruction becomes valid after edge N+1 (2-cycle redirect penalty).
- Release of back-pressure: full FIFO with out_ready rising in cycle N -> pop and fetch both occur at edge N; count stays DEPTH.
- out_* are driven from FIFO registers only, with no combinational path from imem_data. out_valid does not depend combinationally on out_ready.

## Test plan
- Reset then stream, RESET_PC = 0, ROM[i] = 0xA000_0000+i, out_ready = 1 -> out_valid rises the cycle after reset release. Then out_pc = 0,4,8,... and out_instr = 0xA000_0000,0xA000_0001,... with no gaps. out_pc_plus4 = out_pc+4.
- Back-pressure, DEPTH = 2: out_ready = 0 for 5 cycles -> count saturates at 2 and imem_addr holds at 8. On raising out_ready, pops deliver PCs 0, 4, 8 in order with no loss or duplication.
- Redirect with pop: redirect_valid = 1, redirect_pc = 0x0000_0103 while head PC = 0x10 is being popped and the FIFO is full. -> 0x10 is consumed, 0x14 is discarded. The next valid output has out_pc = 0x100 two cycles later.
- Halt: halt = 1 with 2 entries buffered and out_ready = 1 -> both entries drain. Then out_valid = 0 and imem_addr stays constant. Deasserting halt resumes from that address.
- Wrap-around: redirect to 0xFFFF_FFF8 -> outputs PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. out_pc_plus4 for 0xFFFF_FFFC = 0x0000_0000.
- Async reset mid-stream: assert rst between clock edges with count = 2 -> out_valid = 0 and imem_addr = RESET_PC immediately, before the next edge. After release, the stream restarts at RESET_PC.
